// File: rtl/mmio_timer_responder_pkg.sv
// Shared definitions for the MMIO timer: register indices, CTRL field
// positions, MODE encodings, FSM states and a byte-lane merge helper.
package mmio_timer_responder_pkg;

   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_PRESET = 2'd1;
   localparam logic [1:0] TMR_COUNT  = 2'd2;
   localparam logic [1:0] TMR_ACK    = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_W        = 4;

   typedef enum logic [1:0] {
      TMR_ONESHOT = 2'b00,
      TMR_RELOAD  = 2'b01
   } tmr_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tmr_state_e;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mmio_timer_responder_if.sv
// Processor M-stage data port as seen by a memory-mapped responder.
interface mmio_timer_responder_if;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_data_rdata;
   logic        hit;

   modport master (
      output m_data_addr, m_data_wdata, m_data_byteen,
      input  m_data_rdata, hit
   );

   modport slave (
      input  m_data_addr, m_data_wdata, m_data_byteen,
      output m_data_rdata, hit
   );
endinterface

// File: rtl/mmio_timer_responder_timer_core.sv
// Down-counting timer FSM: owns COUNT and irq_flag, asks the register
// block to drop EN when a one-shot run expires.
module timer_core
   import mmio_timer_responder_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] preset,
   input  logic             clear_irq,
   input  logic             force_idle,
   output logic [WIDTH-1:0] count,
   output logic             irq_flag,
   output logic             clr_en
);

   tmr_state_e       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             irq_flag_q, irq_flag_d;
   logic             expire;

   assign expire = (count_q <= WIDTH'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_CNT;
         ST_CNT: begin
            if (!en)         state_d = ST_IDLE;
            else if (expire) state_d = ST_INT;
         end
         ST_INT:  state_d = (mode == TMR_RELOAD) ? ST_LOAD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // A CPU write of EN=0 wins over wherever the FSM was heading.
      if (force_idle && (state_q == ST_CNT || state_q == ST_INT))
         state_d = ST_IDLE;
   end

   always_comb begin
      count_d    = count_q;
      irq_flag_d = irq_flag_q;
      clr_en     = 1'b0;
      case (state_q)
         ST_LOAD: count_d = preset;
         ST_CNT: begin
            if (en && !force_idle) begin
               if (expire) begin
                  count_d    = '0;
                  irq_flag_d = 1'b1;
               end else begin
                  count_d = count_q - WIDTH'(1);
               end
            end
         end
         ST_INT: begin
            if (mode == TMR_RELOAD) irq_flag_d = 1'b0;
            else                    clr_en     = 1'b1;
         end
         default: begin
         end
      endcase
      if (clear_irq) irq_flag_d = 1'b0;
   end

   assign count    = count_q;
   assign irq_flag = irq_flag_q;

endmodule

// File: rtl/mmio_timer_responder.sv
// MMIO timer responder: address decode, byte-lane CTRL/PRESET writes, read mux.
// Optional MMIO_TIMER_IRQ_ACK_EN turns word 3 into an irq_flag ACK register.
module mmio_timer_responder
   import mmio_timer_responder_pkg::*;
#(
   parameter logic [31:0] BASE  = 32'h0000_7F00,
   parameter int          WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   mmio_timer_responder_if.slave        bus,
   output logic                         irq
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0]  preset_q, preset_d;
   logic              irq_q, irq_d;

   logic              hit_w;
   logic [1:0]        widx;
   logic              wr_any, ctrl_wr, preset_wr;
   logic              clear_irq, force_idle, clr_en, irq_flag;
   logic [WIDTH-1:0]  count;
   logic [31:0]       preset_merged;
   logic [31:0]       rdata_w;
   logic              addr_lsb_unused;

   assign hit_w           = (bus.m_data_addr[31:4] == BASE[31:4]);
   assign widx            = bus.m_data_addr[3:2];
   assign addr_lsb_unused = ^bus.m_data_addr[1:0];
   assign wr_any          = hit_w && (bus.m_data_byteen != 4'b0000);
   assign ctrl_wr         = wr_any && (widx == TMR_CTRL);
   assign preset_wr       = wr_any && (widx == TMR_PRESET);

   // All CTRL fields live in byte lane 0; other lanes are not stored.
   assign force_idle = ctrl_wr && bus.m_data_byteen[0] && !bus.m_data_wdata[CTRL_EN_BIT];

`ifdef MMIO_TIMER_IRQ_ACK_EN
   assign clear_irq = wr_any && (widx == TMR_ACK);
`else
   assign clear_irq = ctrl_wr;
`endif

   assign preset_merged = lane_merge(32'(preset_q), bus.m_data_wdata, bus.m_data_byteen);

   always_comb begin
      ctrl_d = ctrl_q;
      if (clr_en) ctrl_d[CTRL_EN_BIT] = 1'b0;
      if (ctrl_wr && bus.m_data_byteen[0]) ctrl_d = bus.m_data_wdata[CTRL_W-1:0];
      preset_d = preset_wr ? preset_merged[WIDTH-1:0] : preset_q;
      irq_d    = irq_flag & ctrl_q[CTRL_IM_BIT];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q   <= '0;
         preset_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         irq_q    <= irq_d;
      end
   end

   timer_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .reset      (reset),
      .en         (ctrl_q[CTRL_EN_BIT]),
      .mode       (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]),
      .preset     (preset_q),
      .clear_irq  (clear_irq),
      .force_idle (force_idle),
      .count      (count),
      .irq_flag   (irq_flag),
      .clr_en     (clr_en)
   );

   always_comb begin
      rdata_w = 32'h0;
      if (hit_w) begin
         case (widx)
            TMR_CTRL:   rdata_w = 32'(ctrl_q);
            TMR_PRESET: rdata_w = 32'(preset_q);
            TMR_COUNT:  rdata_w = 32'(count);
`ifdef MMIO_TIMER_IRQ_ACK_EN
            TMR_ACK:    rdata_w = {31'b0, irq_flag};
`endif
            default:    rdata_w = 32'h0;
         endcase
      end
   end

   assign bus.m_data_rdata = rdata_w;
   assign bus.hit          = hit_w;
   assign irq              = irq_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder: register vector table plus
// hand-timed sequences for one-shot, auto-reload, masking and reset.
module tb_mmio_timer_responder;

   localparam logic [31:0] BASE = 32'h0000_7F00;

   logic clk;
   logic reset;
   logic irq;

   mmio_timer_responder_if bus ();

   mmio_timer_responder #(.BASE(BASE), .WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
      logic [3:0]  wr_be;
      logic [31:0] rd_addr;
      logic [31:0] exp_rdata;
      logic        exp_hit;
   } vec_t;

   vec_t vecs [15];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called inside the low clock phase; the write commits at the next rising edge.
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.m_data_addr   = a;
      bus.m_data_wdata  = d;
      bus.m_data_byteen = be;
      @(negedge clk);
      bus.m_data_byteen = 4'b0000;
   endtask

   task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      bus.m_data_addr   = a;
      bus.m_data_byteen = 4'b0000;
      #1;
      check32(name, bus.m_data_rdata, exp);
   endtask

   task automatic chk_irq(input string name, input logic exp);
      check32(name, {31'b0, irq}, {31'b0, exp});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{BASE,      32'h0,         4'h0, BASE,      32'h0,         1'b1};
      vecs[1]  = '{BASE,      32'h0,         4'h0, BASE + 4,  32'h0,         1'b1};
      vecs[2]  = '{BASE,      32'h0,         4'h0, BASE + 8,  32'h0,         1'b1};
      vecs[3]  = '{BASE + 4,  32'hA1B2C3D4,  4'h3, BASE + 4,  32'h0000C3D4,  1'b1};
      vecs[4]  = '{BASE + 8,  32'hFFFFFFFF,  4'hF, BASE + 8,  32'h0,         1'b1};
      vecs[5]  = '{BASE + 6,  32'h55667788,  4'hC, BASE + 4,  32'h5566C3D4,  1'b1};
      vecs[6]  = '{BASE + 16, 32'hFFFFFFFF,  4'hF, BASE + 16, 32'h0,         1'b0};
      vecs[7]  = '{BASE,      32'h0,         4'h0, BASE,      32'h0,         1'b1};
      vecs[8]  = '{BASE,      32'hFFFFFFF6,  4'h1, BASE,      32'h6,         1'b1};
      vecs[9]  = '{BASE,      32'h000000FF,  4'hE, BASE,      32'h6,         1'b1};
      vecs[10] = '{BASE + 12, 32'hFFFFFFFF,  4'hF, BASE + 12, 32'h0,         1'b1};
      vecs[11] = '{BASE,      32'h0,         4'hF, BASE + 1,  32'h0,         1'b1};
      vecs[12] = '{BASE,      32'h0,         4'h0, BASE + 7,  32'h5566C3D4,  1'b1};
      vecs[13] = '{BASE - 4,  32'hFFFFFFFF,  4'hF, BASE - 4,  32'h0,         1'b0};
      vecs[14] = '{BASE,      32'h0,         4'h0, BASE + 4,  32'h5566C3D4,  1'b1};

      reset             = 1'b1;
      bus.m_data_addr   = BASE;
      bus.m_data_wdata  = 32'h0;
      bus.m_data_byteen = 4'b0000;
      tick(2);
      chk_rd("rst_ctrl", BASE, 32'h0);
      chk_rd("rst_count", BASE + 8, 32'h0);
      chk_irq("rst_irq", 1'b0);
      reset = 1'b0;
      tick(1);

      // Register-level vectors with the timer disabled.
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].wr_be != 4'b0000)
            bus_wr(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_be);
         chk_rd($sformatf("vec%0d_rdata", i), vecs[i].rd_addr, vecs[i].exp_rdata);
         check32($sformatf("vec%0d_hit", i), {31'b0, bus.hit}, {31'b0, vecs[i].exp_hit});
         $display("vec %0d: wr %h/%h be=%b, rd %h -> %h hit=%b", i, vecs[i].wr_addr,
                  vecs[i].wr_data, vecs[i].wr_be, vecs[i].rd_addr, bus.m_data_rdata, bus.hit);
      end

      // One-shot, PRESET=3, IM=1.
      bus_wr(BASE + 4, 32'd3, 4'hF);
      bus_wr(BASE, 32'h9, 4'hF);
      tick(2); chk_rd("os_cnt3", BASE + 8, 32'd3);
      tick(1); chk_rd("os_cnt2", BASE + 8, 32'd2);
      tick(1); chk_rd("os_cnt1", BASE + 8, 32'd1);
      tick(1); chk_rd("os_cnt0", BASE + 8, 32'd0);
      chk_irq("os_irq_int", 1'b0);
      chk_rd("os_ctrl_int", BASE, 32'h9);
      tick(1); chk_irq("os_irq_rise", 1'b1);
      chk_rd("os_ctrl_en_clr", BASE, 32'h8);
      tick(3); chk_irq("os_irq_hold", 1'b1);
      bus_wr(BASE, 32'h0, 4'hF);
      chk_irq("os_irq_lag", 1'b1);
      tick(1); chk_irq("os_irq_drop", 1'b0);
      $display("oneshot sequence done");
`ifdef MMIO_TIMER_IRQ_ACK_EN
      bus_wr(BASE + 12, 32'h0, 4'h1);
`endif

      // Auto-reload, PRESET=2: pulse period is LOAD, CNT, CNT, INT.
      bus_wr(BASE + 4, 32'd2, 4'hF);
      bus_wr(BASE, 32'hB, 4'hF);
      for (int k = 0; k < 16; k++) begin
         tick(1);
         chk_irq($sformatf("ar_irq_k%0d", k), (k > 0) && (k % 4 == 0));
      end
      chk_rd("ar_ctrl", BASE, 32'hB);
      bus_wr(BASE, 32'h0, 4'hF);
      tick(2); chk_irq("ar_stop", 1'b0);
      $display("autoreload sequence done");

      // Masked expiry with PRESET=1 (single CNT cycle).
      bus_wr(BASE + 4, 32'd1, 4'hF);
      bus_wr(BASE, 32'h1, 4'hF);
      tick(2); chk_rd("mk_cnt1", BASE + 8, 32'd1);
      tick(1); chk_rd("mk_cnt0", BASE + 8, 32'd0);
      chk_irq("mk_irq_int", 1'b0);
      tick(1); chk_rd("mk_ctrl", BASE, 32'h0);
      chk_irq("mk_irq_masked", 1'b0);
      tick(2); chk_irq("mk_irq_masked2", 1'b0);
      bus_wr(BASE, 32'h8, 4'hF);
      chk_irq("mk_irq_lag", 1'b0);
      tick(1);
`ifdef MMIO_TIMER_IRQ_ACK_EN
      chk_irq("mk_irq_unmask", 1'b1);
      chk_rd("mk_ack_rd1", BASE + 12, 32'h1);
      bus_wr(BASE + 12, 32'h0, 4'b0100);
      chk_irq("mk_ack_lag", 1'b1);
      tick(1); chk_irq("mk_ack_drop", 1'b0);
      chk_rd("mk_ack_rd0", BASE + 12, 32'h0);
`else
      chk_irq("mk_irq_ctrl_clr", 1'b0);
`endif
      $display("mask sequence done");

      // PRESET rewrite mid-count, then EN=0 holds COUNT.
      bus_wr(BASE + 4, 32'd4, 4'hF);
      bus_wr(BASE, 32'h9, 4'hF);
      tick(2); chk_rd("pw_cnt4", BASE + 8, 32'd4);
      bus_wr(BASE + 4, 32'd100, 4'hF);
      chk_rd("pw_cnt3", BASE + 8, 32'd3);
      tick(1); chk_rd("pw_cnt2", BASE + 8, 32'd2);
      bus_wr(BASE, 32'h8, 4'hF);
      chk_rd("fi_hold", BASE + 8, 32'd2);
      tick(2); chk_rd("fi_hold2", BASE + 8, 32'd2);
      chk_irq("fi_irq", 1'b0);
      bus_wr(BASE, 32'h9, 4'hF);
      tick(2); chk_rd("pw_reload", BASE + 8, 32'd100);
      bus_wr(BASE, 32'h0, 4'hF);
      $display("preset-write sequence done");

      // PRESET=0 expires after one CNT cycle.
      bus_wr(BASE + 4, 32'd0, 4'hF);
      bus_wr(BASE, 32'h9, 4'hF);
      tick(2); chk_rd("p0_cnt", BASE + 8, 32'd0);
      tick(1); chk_irq("p0_irq_int", 1'b0);
      tick(1); chk_irq("p0_irq_rise", 1'b1);
      bus_wr(BASE, 32'h0, 4'hF);
      tick(1); chk_irq("p0_irq_drop", 1'b0);
      $display("preset-zero sequence done");

      // Asynchronous reset mid-count at COUNT=5.
      bus_wr(BASE + 4, 32'd10, 4'hF);
      bus_wr(BASE, 32'h9, 4'hF);
      tick(7); chk_rd("rm_cnt5", BASE + 8, 32'd5);
      reset = 1'b1;
      chk_rd("rm_count", BASE + 8, 32'd0);
      chk_rd("rm_ctrl", BASE, 32'h0);
      chk_rd("rm_preset", BASE + 4, 32'h0);
      chk_irq("rm_irq", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      tick(3); chk_rd("rm_idle_cnt", BASE + 8, 32'd0);
      chk_irq("rm_idle_irq", 1'b0);
      $display("reset-mid-count sequence done");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
